// File: rtl/bsk_com_filter_if.sv
// Command-line bundle between the raw optocoupler side and the filtered BskPRD side.
// The slave modport is the filter; the master modport is whatever drives the raw lines.
interface bsk_com_filter_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] iComRaw;
    logic             iEvtClr;
    logic [WIDTH-1:0] oCom;
    logic             oChange;
    logic [WIDTH-1:0] oEvt;
    logic             oEvtAny;
    logic             oTick;

    modport master (
        output iComRaw, iEvtClr,
        input  oCom, oChange, oEvt, oEvtAny, oTick
    );

    modport slave (
        input  iComRaw, iEvtClr,
        output oCom, oChange, oEvt, oEvtAny, oTick
    );
endinterface

// File: rtl/bsk_com_filter.sv
// Command input conditioning: 2-FF synchroniser, tick-based debounce per channel,
// filtered command register and sticky per-channel change flags.
module bsk_com_filter #(
    parameter int WIDTH      = 16,
    parameter int TICK_DIV   = 20,
    parameter int FILTER_LEN = 8,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              iRes,
    bsk_com_filter_if.slave   bus
);
    localparam int                PCNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FILTER_LEN - 1);

    logic [WIDTH-1:0]  s1_q, s2_q;
    logic [WIDTH-1:0]  com_q, com_d;
    logic [WIDTH-1:0]  evt_q, evt_d;
    logic [WIDTH-1:0]  acc;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              tick;
    logic              tick_q;
    logic              chg_q;

    assign tick   = (pcnt_q == PCNT_LAST);
    assign pcnt_d = tick ? '0 : pcnt_q + PCNT_W'(1);

    // Any clk where the synchronised level equals the accepted one restarts the window.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (s2_q[gi] == com_q[gi]) begin
                cnt_d = '0;
            end else if (tick) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        assign acc[gi] = (s2_q[gi] != com_q[gi]) && tick && (cnt_q == CNT_LAST);

        always_ff @(posedge clk or negedge iRes) begin
            if (!iRes) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign com_d = (com_q & ~acc) | (s2_q & acc);
    // A fresh acceptance wins over a coincident clear.
    assign evt_d = acc | (evt_q & ~{WIDTH{bus.iEvtClr}});

    always_ff @(posedge clk or negedge iRes) begin
        if (!iRes) begin
            s1_q   <= '0;
            s2_q   <= '0;
            pcnt_q <= '0;
            tick_q <= 1'b0;
            com_q  <= '0;
            chg_q  <= 1'b0;
            evt_q  <= '0;
        end else begin
            s1_q   <= bus.iComRaw;
            s2_q   <= s1_q;
            pcnt_q <= pcnt_d;
            tick_q <= tick;
            com_q  <= com_d;
            chg_q  <= |acc;
            evt_q  <= evt_d;
        end
    end

    assign bus.oCom    = com_q;
    assign bus.oChange = chg_q;
    assign bus.oEvt    = evt_q;
    assign bus.oEvtAny = |evt_q;
    assign bus.oTick   = tick_q;
endmodule

// File: tb/tb_bsk_com_filter.sv
// Scenario bench for bsk_com_filter with TICK_DIV=4, FILTER_LEN=3; a scoreboard
// holds the expected oCom/oEvt for every oChange pulse.
module tb_bsk_com_filter;
    logic clk = 1'b0;
    logic iRes;
    int   n_checks = 0;
    int   n_pass   = 0;

    typedef struct {
        logic [15:0] com;
        logic [15:0] evt;
    } exp_t;
    exp_t sb_q[$];
    exp_t sb_e;

    bsk_com_filter_if #(.WIDTH(16)) bus ();

    bsk_com_filter #(
        .WIDTH(16), .TICK_DIV(4), .FILTER_LEN(3), .CNT_W(4)
    ) dut (
        .clk  (clk),
        .iRes (iRes),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    // Scoreboard monitor: every oChange pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (iRes === 1'b1 && bus.oChange === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected_change: oCom=%h oEvt=%h, expected no change", bus.oCom, bus.oEvt);
            end else begin
                n_pass++;
                sb_e = sb_q.pop_front();
                n_checks++;
                if (bus.oCom !== sb_e.com) $display("FAIL sb_com: got %h, expected %h", bus.oCom, sb_e.com);
                else n_pass++;
                n_checks++;
                if (bus.oEvt !== sb_e.evt) $display("FAIL sb_evt: got %h, expected %h", bus.oEvt, sb_e.evt);
                else n_pass++;
                $display("change: oCom=%h oEvt=%h at %0t", bus.oCom, bus.oEvt, $time);
            end
        end
    end

    task automatic sync_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.oTick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        iRes = 1'b1;
        bus.iComRaw = 16'hFFFF;
        bus.iEvtClr = 1'b0;
        #1 iRes = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (bus.oCom !== 16'h0000) $display("FAIL rst_com: got %h, expected 0000", bus.oCom); else n_pass++;
        n_checks++; if (bus.oEvt !== 16'h0000) $display("FAIL rst_evt: got %h, expected 0000", bus.oEvt); else n_pass++;
        n_checks++; if (bus.oChange !== 1'b0) $display("FAIL rst_change: got %b, expected 0", bus.oChange); else n_pass++;
        n_checks++; if (bus.oTick !== 1'b0) $display("FAIL rst_tick: got %b, expected 0", bus.oTick); else n_pass++;
        n_checks++; if (bus.oEvtAny !== 1'b0) $display("FAIL rst_evtany: got %b, expected 0", bus.oEvtAny); else n_pass++;
        bus.iComRaw = 16'h0000;
        @(negedge clk);
        iRes = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.oCom !== 16'h0000) $display("FAIL rst_release_com: got %h, expected 0000", bus.oCom); else n_pass++;
        $display("reset: oCom=%h oEvt=%h", bus.oCom, bus.oEvt);
    endtask

    task automatic test_step();
        int lat;
        bit seen, ok;
        lat = 0;
        seen = 1'b0;
        sb_q.push_back('{com: 16'h0001, evt: 16'h0001});
        bus.iComRaw = 16'h0001;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (bus.oCom[0] === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++; if (!seen || lat < 11 || lat > 15) $display("FAIL step_latency: got %0d clk (seen=%b), expected 11..15", lat, seen); else n_pass++;
        n_checks++; if (bus.oChange !== 1'b1) $display("FAIL step_change_hi: got %b, expected 1", bus.oChange); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.oChange !== 1'b0) $display("FAIL step_change_lo: got %b, expected 0", bus.oChange); else n_pass++;
        n_checks++; if (bus.oEvt !== 16'h0001) $display("FAIL step_evt: got %h, expected 0001", bus.oEvt); else n_pass++;
        n_checks++; if (bus.oEvtAny !== 1'b1) $display("FAIL step_evtany: got %b, expected 1", bus.oEvtAny); else n_pass++;
        wait_drain(5, ok);
        n_checks++; if (!ok) $display("FAIL step_drain: %0d entries left, expected 0", sb_q.size()); else n_pass++;
        $display("step: latency=%0d oCom=%h", lat, bus.oCom);
    endtask

    task automatic test_glitch();
        int pulses;
        pulses = 0;
        bus.iComRaw[5] = 1'b1;
        repeat (6) @(negedge clk);
        bus.iComRaw[5] = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.oChange === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0) $display("FAIL glitch_change: got %0d pulses, expected 0", pulses); else n_pass++;
        n_checks++; if (bus.oCom !== 16'h0001) $display("FAIL glitch_com: got %h, expected 0001", bus.oCom); else n_pass++;
        n_checks++; if (bus.oEvt !== 16'h0001) $display("FAIL glitch_evt: got %h, expected 0001", bus.oEvt); else n_pass++;
        $display("glitch: oCom=%h oEvt=%h", bus.oCom, bus.oEvt);
    endtask

    task automatic test_dropout();
        bit ok;
        sync_tick(ok);
        n_checks++; if (!ok) $display("FAIL drop_sync: no oTick, expected one within 12 clk"); else n_pass++;
        bus.iComRaw[8] = 1'b1;
        sb_q.push_back('{com: 16'h0101, evt: 16'h0101});
        repeat (7) @(negedge clk);
        bus.iComRaw[8] = 1'b0;
        @(negedge clk);
        bus.iComRaw[8] = 1'b1;
        repeat (11) @(negedge clk);
        n_checks++; if (bus.oCom[8] !== 1'b0) $display("FAIL drop_early: got oCom=%h, expected bit8 still 0", bus.oCom); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.oCom !== 16'h0101) $display("FAIL drop_accept: got %h, expected 0101", bus.oCom); else n_pass++;
        wait_drain(3, ok);
        n_checks++; if (!ok) $display("FAIL drop_drain: %0d entries left, expected 0", sb_q.size()); else n_pass++;
        $display("dropout: oCom=%h", bus.oCom);
    endtask

    task automatic test_multi();
        int pulses;
        pulses = 0;
        @(negedge clk);
        iRes = 1'b0;
        bus.iComRaw = 16'h0000;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.oCom !== 16'h0000 || bus.oEvt !== 16'h0000) $display("FAIL multi_rst: got oCom=%h oEvt=%h, expected 0000/0000", bus.oCom, bus.oEvt); else n_pass++;
        iRes = 1'b1;
        @(negedge clk);
        sb_q.push_back('{com: 16'h1331, evt: 16'h1331});
        bus.iComRaw = 16'h1331;
        repeat (25) begin
            @(negedge clk);
            if (bus.oChange === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 1) $display("FAIL multi_pulses: got %0d, expected 1", pulses); else n_pass++;
        n_checks++; if (bus.oCom !== 16'h1331) $display("FAIL multi_com: got %h, expected 1331", bus.oCom); else n_pass++;
        n_checks++; if (bus.oEvt !== 16'h1331) $display("FAIL multi_evt: got %h, expected 1331", bus.oEvt); else n_pass++;
        n_checks++; if (sb_q.size() != 0) $display("FAIL multi_drain: %0d entries left, expected 0", sb_q.size()); else n_pass++;
        $display("multi: oCom=%h oEvt=%h pulses=%0d", bus.oCom, bus.oEvt, pulses);
    endtask

    task automatic test_clear_vs_set();
        bit ok;
        sync_tick(ok);
        n_checks++; if (!ok) $display("FAIL clr_sync: no oTick, expected one within 12 clk"); else n_pass++;
        bus.iComRaw = 16'h1321;
        sb_q.push_back('{com: 16'h1321, evt: 16'h0010});
        repeat (11) @(negedge clk);
        n_checks++; if (bus.oEvt !== 16'h1331) $display("FAIL clr_pre_evt: got %h, expected 1331", bus.oEvt); else n_pass++;
        bus.iEvtClr = 1'b1;
        @(negedge clk);
        bus.iEvtClr = 1'b0;
        n_checks++; if (bus.oCom !== 16'h1321) $display("FAIL clr_com: got %h, expected 1321", bus.oCom); else n_pass++;
        n_checks++; if (bus.oEvt !== 16'h0010) $display("FAIL clr_set_wins: got %h, expected 0010", bus.oEvt); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.oEvtAny !== 1'b1) $display("FAIL clr_any_hi: got %b, expected 1", bus.oEvtAny); else n_pass++;
        bus.iEvtClr = 1'b1;
        @(negedge clk);
        bus.iEvtClr = 1'b0;
        n_checks++; if (bus.oEvt !== 16'h0000) $display("FAIL clr_evt: got %h, expected 0000", bus.oEvt); else n_pass++;
        n_checks++; if (bus.oEvtAny !== 1'b0) $display("FAIL clr_any_lo: got %b, expected 0", bus.oEvtAny); else n_pass++;
        $display("clear: oCom=%h oEvt=%h", bus.oCom, bus.oEvt);
    endtask

    task automatic test_reset_midcount();
        bit ok;
        int ticks;
        ticks = 0;
        sync_tick(ok);
        n_checks++; if (!ok) $display("FAIL mid_sync: no oTick, expected one within 12 clk"); else n_pass++;
        bus.iComRaw = 16'h9321;
        repeat (8) @(negedge clk);
        n_checks++; if (bus.oCom !== 16'h1321) $display("FAIL mid_pre_com: got %h, expected 1321", bus.oCom); else n_pass++;
        #2 iRes = 1'b0;
        #1;
        n_checks++; if (bus.oCom !== 16'h0000) $display("FAIL mid_async_com: got %h, expected 0000", bus.oCom); else n_pass++;
        n_checks++; if (bus.oEvt !== 16'h0000 || bus.oEvtAny !== 1'b0) $display("FAIL mid_async_evt: got %h/%b, expected 0000/0", bus.oEvt, bus.oEvtAny); else n_pass++;
        n_checks++; if (bus.oChange !== 1'b0 || bus.oTick !== 1'b0) $display("FAIL mid_async_strobes: got chg=%b tick=%b, expected 0/0", bus.oChange, bus.oTick); else n_pass++;
        repeat (2) @(negedge clk);
        iRes = 1'b1;
        sb_q.push_back('{com: 16'h9321, evt: 16'h9321});
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (bus.oTick === 1'b1) ticks++;
        end
        n_checks++; if (bus.oCom !== 16'h0000) $display("FAIL mid_hold_com: got %h, expected 0000", bus.oCom); else n_pass++;
        n_checks++; if (ticks != 2) $display("FAIL mid_tick_count: got %0d, expected 2", ticks); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.oCom !== 16'h9321) $display("FAIL mid_accept_com: got %h, expected 9321", bus.oCom); else n_pass++;
        n_checks++; if (bus.oTick !== 1'b1) $display("FAIL mid_third_tick: got %b, expected 1", bus.oTick); else n_pass++;
        wait_drain(3, ok);
        n_checks++; if (!ok) $display("FAIL mid_drain: %0d entries left, expected 0", sb_q.size()); else n_pass++;
        $display("reset_midcount: oCom=%h oEvt=%h", bus.oCom, bus.oEvt);
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_dropout();
        test_multi();
        test_clear_vs_set();
        test_reset_midcount();
        repeat (5) @(negedge clk);
        n_checks++; if (sb_q.size() != 0) $display("FAIL sb_leftover: %0d entries, expected 0", sb_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
